// File: rtl/npc_trace_pkg.sv
// Shared types for the retirement trace path: halt encoding, FSM states, trace entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_trace_pkg;

   // Full 32-bit ebreak encoding; only an exact match halts the core.
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   // Reference pc width of the trace entry record.
   localparam int TRACE_XLEN = 64;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DUMP = 2'd1,
      HALT = 2'd2
   } trace_state_e;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [31:0]           inst;
   } trace_entry_t;

endpackage

// File: rtl/trace_ring.sv
// Ring of the last DEPTH entries with write pointer, read pointer and occupancy count.
// Latency: a write is readable one cycle later; rd_data is combinational from the registered rd_ptr.
// Backpressure: none inside; the owner decides when to write, load the read pointer or advance it.
module trace_ring #(
   parameter int DEPTH = 16,
   parameter int W     = 96
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     load_rd,
   input  logic                     rd_adv,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt_next;

   // Occupancy saturates at DEPTH on write (oldest entry gets overwritten) and drops on each read.
   always_comb begin
      cnt_next = count;
      if (wr_en) begin
         cnt_next = (count == CNT_FULL) ? CNT_FULL : count + CNT_ONE;
      end else if (rd_adv) begin
         cnt_next = count - CNT_ONE;
      end
   end

   // Storage is not reset; stale contents are never presented because count gates validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and count registers. On load the read pointer lands on the oldest entry
   // that survives the write happening in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= cnt_next;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (load_rd) begin
            rd_ptr <= wr_ptr + PTR_ONE - cnt_next[AW-1:0];
         end else if (rd_adv) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/commit_trace_buf.sv
// Records the last DEPTH retirements, and on ebreak freezes, captures a0 and drains oldest-first.
// Latency: commit visible in retire_cnt_o next cycle; dump starts the cycle after ebreak; halt the cycle after last accept.
// Backpressure: dump payload held stable while dump_ready_i is low; commits are dropped outside RUN.
module commit_trace_buf
   import npc_trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int XLEN  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic [31:0]     commit_inst_i,
   input  logic [XLEN-1:0] a0_i,
   output logic            dump_valid_o,
   input  logic            dump_ready_i,
   output logic [XLEN-1:0] dump_pc_o,
   output logic [31:0]     dump_inst_o,
   output logic            dump_last_o,
   output logic            halted_o,
   output logic [XLEN-1:0] halt_code_o,
   output logic [63:0]     retire_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = XLEN + 32;
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   trace_state_e    state_q;
   trace_state_e    state_d;
   logic            wr_en;
   logic            load_rd;
   logic            rd_adv;
   logic [EW-1:0]   rd_data;
   logic [AW:0]     count;

   trace_ring #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data ({commit_pc_i, commit_inst_i}),
      .load_rd (load_rd),
      .rd_adv  (rd_adv),
      .rd_data (rd_data),
      .count   (count)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and ring control: record in RUN, drain in DUMP, hold forever in HALT.
   always_comb begin
      state_d      = state_q;
      wr_en        = 1'b0;
      load_rd      = 1'b0;
      rd_adv       = 1'b0;
      dump_valid_o = 1'b0;
      case (state_q)
         RUN: begin
            if (commit_valid_i) begin
               wr_en = 1'b1;
               if (commit_inst_i == EBREAK_INST) begin
                  load_rd = 1'b1;
                  state_d = DUMP;
               end
            end
         end
         DUMP: begin
            dump_valid_o = 1'b1;
            if (dump_ready_i) begin
               rd_adv = 1'b1;
               if (count == CNT_ONE) begin
                  state_d = HALT;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Retirement counter and exit-code capture; both only move while recording.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt_o <= '0;
         halt_code_o  <= '0;
      end else begin
         if (wr_en) begin
            retire_cnt_o <= retire_cnt_o + 64'd1;
         end
         if (load_rd) begin
            halt_code_o <= a0_i;
         end
      end
   end

   // Payload is zeroed outside DUMP so idle and reset values are clean.
   assign dump_pc_o   = dump_valid_o ? rd_data[EW-1:32] : '0;
   assign dump_inst_o = dump_valid_o ? rd_data[31:0]    : '0;
   assign dump_last_o = (state_q == DUMP) && (count == CNT_ONE);
   assign halted_o    = (state_q == HALT);

endmodule

// File: doc/commit_trace_buf.md
# commit_trace_buf

Retirement-side trace stage placed directly upstream of the simulation DPI bridge. It records the last DEPTH retired instructions as {pc, inst} in a ring buffer and counts retirements. When an `ebreak` (32'h0010_0073) retires, it freezes the buffer, captures the exit code from a0, and drains the buffer oldest-first over a valid/ready port. After the drain, the halt indication is raised for the bridge.

## Interface
- `DEPTH`, 16: ring entries; power of two, ≥2.
- `XLEN`, 64: pc/data width.

- `clk` input 1: core clock.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `commit_valid_i` input 1: one instruction retires this cycle.
- `commit_pc_i` input XLEN: pc of the retiring instruction.
- `commit_inst_i` input 32: encoding of the retiring instruction.
- `a0_i` input XLEN: current architectural x10. At ebreak retirement it is the exit code.
- `dump_valid_o` output 1: dump entry available.
- `dump_ready_i` input 1: consumer accepts the dump entry.
- `dump_pc_o` output XLEN: pc of the entry being dumped.
- `dump_inst_o` output 32: inst of the entry being dumped.
- `dump_last_o` output 1: current dump entry is the ebreak itself (the final entry).
- `halted_o` output 1: drain complete; sticky until reset.
- `halt_code_o` output XLEN: a0 captured at ebreak; 0 means good trap.
- `retire_cnt_o` output 64: number of instructions retired, ebreak included.

## Operation
- FSM states:
  - RUN (reset state)
  - DUMP
  - HALT
- Storage and pointers: `mem[DEPTH]` of {pc, inst}; `wr_ptr` and `rd_ptr` of log2(DEPTH) bits; `count` of 0..DEPTH.
- RUN, on each cycle with `commit_valid_i`:
  - write the entry at `wr_ptr`, then `wr_ptr`+1, wrapping modulo DEPTH;
  - `count` = min(`count`+1, DEPTH); when full, the oldest entry is silently overwritten;
  - `retire_cnt_o`+1, wrapping at 2^64.
- RUN, when the retiring inst equals EBREAK:
  - the entry is still written and still counted;
  - `halt_code_o` ← `a0_i`;
  - `rd_ptr` ← (`wr_ptr` − `count_next` + 1) mod DEPTH, i.e. the oldest valid entry after this write;
  - next state is DUMP.
- DUMP:
  - `dump_valid_o`=1, showing `mem[rd_ptr]`;
  - on `dump_valid_o && dump_ready_i`: `rd_ptr`+1 and `count`−1;
  - `dump_last_o` = (`count`==1);
  - acceptance of the last entry moves the state to HALT;
  - `count` is never 0 in DUMP, because the ebreak entry is always present.
- DUMP and HALT ignore `commit_valid_i` entirely: no write, no counter change.
- HALT: `halted_o`=1 and `dump_valid_o`=0. There is no exit except `rst_n`.
- Non-ebreak encodings that happen to match in other fields are not treated as halts; the compare is on all 32 bits.
- Reset, including assertion mid-DUMP: every register is cleared immediately, the state returns to RUN, and buffer contents are discarded. `mem` need not be cleared.

## Timing
- Reset values: `dump_valid_o`=0, `dump_pc_o`=0, `dump_inst_o`=0, `dump_last_o`=0, `halted_o`=0, `halt_code_o`=0, `retire_cnt_o`=0.
- Write latency: a commit in cycle t is visible in `retire_cnt_o` at t+1.
- Dump start: the ebreak commit in cycle t gives `dump_valid_o`=1 at t+1. All dump outputs are driven from registers or from `mem` indexed by the registered `rd_ptr`; there is no combinational path from the commit inputs.
- Dump handshake:
  - `dump_valid_o` and the dump payload stay stable while `dump_ready_i`=0;
  - with `dump_ready_i` held at 1, one entry is accepted per cycle.
- Halt: last accept in cycle t gives `halted_o`=1 at t+1.
- A commit and the ebreak cannot coincide, because there is one commit per cycle. A commit in the cycle after ebreak is dropped.

## Structure
- Shared package `npc_trace_pkg` holds:
  - `EBREAK_INST` = 32'h0010_0073;
  - `trace_state_e` {RUN, DUMP, HALT};
  - `trace_entry_t` struct {pc, inst}.
- One natural sub-module, `trace_ring`: parameterised DEPTH×entry storage with write port, read address, and pointer/count logic. The FSM, counters and halt capture stay in `commit_trace_buf`.
- The DPI bridge consumes `halted_o` as its halt input and pulls the dump port.

## Test plan
- **Short program:** reset, then 3 commits at pc 0x8000_0000/04/08 with inst 0x0000_0013, then ebreak at 0x8000_000C with a0=0.
  - `retire_cnt_o`=4.
  - Dump yields 4 entries in pc order; `dump_last_o` only on 0x8000_000C.
  - `halted_o`=1 one cycle after the last accept; `halt_code_o`=0.
- **Wrap-around:** DEPTH=16, 40 commits with pc=0x8000_0000+4k, then ebreak with a0=1.
  - Dump yields exactly 16 entries, starting at pc 0x8000_0064 (k=25) and ending at the ebreak.
  - `halt_code_o`=1; `retire_cnt_o`=41.
- **Backpressure:** during the dump, toggle `dump_ready_i` 1,0,0,1,…
  - Payload is unchanged across stall cycles.
  - No entry is duplicated or skipped.
- **Commits after ebreak:** drive `commit_valid_i`=1 every cycle during DUMP and HALT.
  - `retire_cnt_o` and the dump contents are unchanged.
- **Reset mid-dump:** assert `rst_n`=0 after 2 of 5 entries have been accepted.
  - All outputs are 0 immediately.
  - After release, a fresh run of 2 commits plus ebreak dumps exactly 3 entries.
- **Near-miss encoding:** commit inst 0x0010_0073 XOR 0x0000_0100.
  - No transition out of RUN; `dump_valid_o` stays 0.
